// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider (signed/unsigned) for the
//               execute stage. One quotient bit per cycle; results feed HI/LO.
//               The caller stalls on busy and aborts with cancel on a flush.
// Parameters  : WIDTH  - operand/result width in bits (>= 4)
// Ports       : clk       in   clock, rising edge
//               rst       in   asynchronous active-high reset
//               start     in   request, sampled in IDLE or DONE
//               signed_op in   1 = signed (DIV), 0 = unsigned (DIVU)
//               cancel    in   abort operation in flight, wins over start
//               a, b      in   dividend / divisor, sampled with start
//               busy      out  high while iterating
//               done      out  one-cycle pulse, quot/rem just became valid
//               quot      out  quotient (LO), held until the next done
//               rem       out  remainder (HI), held until the next done
//               div_zero  out  divide-by-zero flag, qualified by done
// Macro       : DIV_ZERO_FAST_EN - when defined, a zero divisor completes in
//               one cycle and raises div_zero; otherwise div_zero is tied 0
//               and a zero divisor takes the normal latency.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_divisor;   // |b|
    logic [WIDTH-1:0]   r_work;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   r_partRem;   // partial remainder, always < divisor (or < 2^(k) when b==0)
    logic               r_negQuot;
    logic               r_negRem;
    logic               r_bZero;

    logic               w_canLaunch;
    logic               w_launch;
    logic               w_bZero;
    logic               w_fastZero;
    logic               w_lastStep;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_workNext;
    logic [WIDTH-1:0]   w_quotFinal;
    logic [WIDTH-1:0]   w_remFinal;

    assign w_canLaunch = (r_state == IDLE) || (r_state == DONE);
    assign w_launch    = w_canLaunch && start && !cancel;
    assign w_bZero     = (b == '0);

`ifdef DIV_ZERO_FAST_EN
    assign w_fastZero = w_launch && w_bZero;
`else
    assign w_fastZero = 1'b0;
`endif

    assign w_lastStep = (r_state == RUN) && !cancel && (r_count == c_CNT_LAST);

    // Magnitudes; negating the most-negative value wraps to itself, which is
    // still the correct unsigned magnitude.
    assign w_absA = (signed_op && a[WIDTH-1]) ? -a : a;
    assign w_absB = (signed_op && b[WIDTH-1]) ? -b : b;

    // One restoring step on a WIDTH+1-bit partial remainder. Bit WIDTH of the
    // difference is a reliable borrow: for a nonzero divisor the shifted value
    // is < 2*divisor, and for a zero divisor the remainder never reaches bit
    // WIDTH-1 before the last shift.
    assign w_shift    = {r_partRem, r_work[WIDTH-1]};
    assign w_sub      = w_shift - {1'b0, r_divisor};
    assign w_ge       = !w_sub[WIDTH];
    assign w_remNext  = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_workNext = {r_work[WIDTH-2:0], w_ge};

    // Sign fix-up. A zero divisor always reports all ones regardless of the
    // sign of a; the remainder naturally comes back as a.
    assign w_quotFinal = r_bZero   ? '1 : (r_negQuot ? -w_workNext : w_workNext);
    assign w_remFinal  = r_negRem  ? -w_remNext : w_remNext;

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_launch) begin
                    w_stateNext = w_fastZero ? DONE : RUN;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            RUN: begin
                if (cancel) begin
                    w_stateNext = IDLE;
                end else if (r_count == c_CNT_LAST) begin
                    w_stateNext = DONE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_divisor <= '0;
            r_work    <= '0;
            r_partRem <= '0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
            r_bZero   <= 1'b0;
            quot      <= '0;
            rem       <= '0;
        end else if (w_fastZero) begin
            quot <= '1;
            rem  <= a;
        end else if (w_launch) begin
            r_count   <= c_CNT_INIT;
            r_divisor <= w_absB;
            r_work    <= w_absA;
            r_partRem <= '0;
            r_negQuot <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_negRem  <= signed_op && a[WIDTH-1];
            r_bZero   <= w_bZero;
        end else if ((r_state == RUN) && !cancel) begin
            r_count   <= r_count - c_CNT_LAST;
            r_work    <= w_workNext;
            r_partRem <= w_remNext;
            if (w_lastStep) begin
                quot <= w_quotFinal;
                rem  <= w_remFinal;
            end
        end
    end

`ifdef DIV_ZERO_FAST_EN
    logic r_divZero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divZero <= 1'b0;
        end else if (w_fastZero) begin
            r_divZero <= 1'b1;
        end else if (w_lastStep) begin
            r_divZero <= 1'b0;
        end
    end

    assign div_zero = r_divZero;
`else
    assign div_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Scoreboard bench for div_unit (WIDTH=32). The driver pushes
//               expected results computed with plain integer arithmetic; a
//               monitor pops and compares whenever done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam int WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             signedOp = 1'b0;
    logic             cancel = 1'b0;
    logic [WIDTH-1:0] opA = '0;
    logic [WIDTH-1:0] opB = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             divZero;

    int   cyc = 0;
    int   nCmp = 0;
    int   nErr = 0;
    exp_t sb[$];
    logic [WIDTH-1:0] lastQ = '0;
    logic [WIDTH-1:0] lastR = '0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signedOp),
        .cancel(cancel), .a(opA), .b(opB), .busy(busy), .done(done),
        .quot(quot), .rem(rem), .div_zero(divZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        nCmp++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Truncating division on 64-bit integers: '/' rounds toward zero and '%'
    // follows the dividend's sign, and MIN/-1 is exact before truncation.
    function automatic exp_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input bit s);
        exp_t   e;
        longint na, nb, q, r;
        if (bb == '0) begin
            q = -1;
            r = longint'({32'b0, aa});
            e.dz = c_FAST;
        end else begin
            na = s ? longint'($signed(aa)) : longint'({32'b0, aa});
            nb = s ? longint'($signed(bb)) : longint'({32'b0, bb});
            q = na / nb;
            r = na % nb;
            e.dz = 1'b0;
        end
        e.q = q[WIDTH-1:0];
        e.r = r[WIDTH-1:0];
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                nCmp++;
                nErr++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quot", quot, e.q);
                check("rem", rem, e.r);
                check("div_zero", {31'b0, divZero}, {31'b0, e.dz});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called just after a rising edge; drives start so the next edge samples it.
    task automatic issue(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input bit s, input bit expectDone);
        exp_t e;
        start = 1'b1; opA = aa; opB = bb; signedOp = s;
        @(posedge clk); #1;
        start = 1'b0;
        if (expectDone) begin
            e = model(aa, bb, s);
            e.cyc = (c_FAST && bb == '0) ? cyc : cyc + WIDTH;
            sb.push_back(e);
            lastQ = e.q;
            lastR = e.r;
        end
    endtask

    task automatic waitDone(input int budget, output int busyCnt);
        busyCnt = 0;
        for (int i = 0; i <= budget; i++) begin
            if (done) return;
            if (busy) busyCnt++;
            @(posedge clk); #1;
        end
        nCmp++;
        nErr++;
        $display("FAIL timeout: got no done expected done within %0d cycles", budget);
    endtask

    task automatic runOp(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input bit s, input string tag);
        int bc;
        issue(aa, bb, s, 1'b1);
        waitDone(WIDTH + 4, bc);
        check({tag, "_busy_cycles"}, bc, (c_FAST && bb == '0) ? 0 : WIDTH);
    endtask

    initial begin
        int bc;
        logic [WIDTH-1:0] ra, rb;
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_quot", quot, 0);
        check("rst_rem", rem, 0);
        check("rst_div_zero", {31'b0, divZero}, 0);

        // Directed arithmetic cases
        runOp(32'd100, 32'd7, 1'b0, "u100_7");
        @(posedge clk); #1;
        runOp(-32'sd7, 32'd2, 1'b1, "s-7_2");
        runOp(32'd7, -32'sd2, 1'b1, "s7_-2");
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "smin_-1");
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "umin_max");
        // Back-to-back: the second start is sampled in the DONE cycle
        issue(32'd100, 32'd7, 1'b0, 1'b1);
        waitDone(WIDTH + 4, bc);
        runOp(32'd20, 32'd3, 1'b0, "b2b_20_3");
        @(posedge clk); #1;

        // Cancel in the 10th RUN cycle; a start raised during RUN is ignored
        issue(32'd50, 32'd5, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; opA = 32'd9; opB = 32'd2;
        repeat (5) begin @(posedge clk); #1; end
        check("run_ignores_start", {31'b0, busy}, 1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        check("cancel_busy", {31'b0, busy}, 0);
        check("cancel_done", {31'b0, done}, 0);
        check("cancel_quot_held", quot, lastQ);
        check("cancel_rem_held", rem, lastR);
        repeat (WIDTH + 8) @(posedge clk);
        #1;

        // Divide by zero, both signs of dividend and both modes
        runOp(32'd5, 32'd0, 1'b0, "u5_0");
        runOp(32'd5, 32'd0, 1'b1, "s5_0");
        runOp(-32'sd5, 32'd0, 1'b1, "s-5_0");
        runOp(32'd9, 32'd4, 1'b0, "after_zero");

        // Reset in the middle of an operation
        issue(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_quot", quot, 0);
        check("midrst_rem", rem, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_idle_done", {31'b0, done}, 0);

        // Randomized operations with corner-biased operands
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 6))
                0: rb = '0;
                1: rb = $urandom_range(1, 15);
                2: rb = '1;
                3: ra = 32'h8000_0000;
                4: rb = -$urandom_range(1, 15);
                default: ;
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            waitDone(WIDTH + 4, bc);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1000000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
